// File: rtl/sync_dp_ram_be.sv
// Simple dual-port RAM: one clock, one write port with per-byte enables and one
// read port. The array is cleared one word per cycle after reset, and the read
// port can optionally add an output register.
//
// Ports:
//   clk        single clock, all logic on posedge
//   rst        asynchronous active-high reset
//   wr_en      write request (wr_addr, wr_data, wr_be)
//   wr_be      byte enables; bit i covers wr_data[8i+7:8i]
//   rd_en      read request (rd_addr)
//   rd_data    read data, valid while rd_valid=1; otherwise holds its last value
//   rd_valid   one-cycle pulse per accepted read, aligned with rd_data
//   init_busy  high while the array is being cleared; requests are ignored
module sync_dp_ram_be #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned RDW_MODE = 0,
  parameter int unsigned OUT_REG  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_busy_d;
  logic              wr_fire_c, rd_fire_c;
  logic [DATA_W-1:0] old_word_c, merged_c, rd_word_c;

  logic [DATA_W-1:0] mem [DEPTH];

  // Next state: INIT walks the clear counter, RUN accepts port requests.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_fire_c = 1'b0;
    rd_fire_c = 1'b0;
    unique case (state_q)
      S_INIT: begin
        cnt_d = ADDR_W'(cnt_q + 1'b1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        wr_fire_c = wr_en;
        rd_fire_c = rd_en;
      end
      default: state_d = S_INIT;
    endcase
    init_busy_d = (state_d == S_INIT);
  end

  // State, clear counter and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      init_busy <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      init_busy <= init_busy_d;
    end
  end

  // Read word, with the write merged in on a same-address collision in WRITE_FIRST mode.
  always_comb begin
    old_word_c = mem[rd_addr];
    merged_c   = old_word_c;
    for (int unsigned i = 0; i < NB; i++) begin
      if (wr_be[i]) merged_c[8*i +: 8] = wr_data[8*i +: 8];
    end
    rd_word_c = old_word_c;
    if ((RDW_MODE == 1) && wr_fire_c && (wr_addr == rd_addr)) rd_word_c = merged_c;
  end

  // Storage: cleared during INIT, byte-masked writes during RUN. No reset on the array.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem[cnt_q] <= '0;
    end else if (wr_fire_c) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read output path, one or two register stages.
  if (OUT_REG == 0) begin : g_direct
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        rd_valid <= rd_fire_c;
        if (rd_fire_c) rd_data <= rd_word_c;
      end
    end
  end else begin : g_piped
    logic              p_valid_q;
    logic [DATA_W-1:0] p_data_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p_valid_q <= 1'b0;
        p_data_q  <= '0;
        rd_valid  <= 1'b0;
        rd_data   <= '0;
      end else begin
        p_valid_q <= rd_fire_c;
        if (rd_fire_c) p_data_q <= rd_word_c;
        rd_valid  <= p_valid_q;
        if (p_valid_q) rd_data <= p_data_q;
      end
    end
  end

endmodule

// File: tb/tb_sync_dp_ram_be.sv
// Bench for sync_dp_ram_be: two instances share stimulus (READ_FIRST/1-cycle and
// WRITE_FIRST/2-cycle). A word-array reference model predicts every read and
// pushes it into per-instance queues; a negedge monitor pops and compares.
module tb_sync_dp_ram_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [2:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, init_busy0, init_busy1;

  always #5 clk = ~clk;

  sync_dp_ram_be #(.DATA_W(32), .ADDR_W(3), .RDW_MODE(0), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .init_busy(init_busy0));

  sync_dp_ram_be #(.DATA_W(32), .ADDR_W(3), .RDW_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .init_busy(init_busy1));

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          mon_on   = 1'b0;
  int          init_left = 8;
  logic [31:0] mdl [8];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // One clock of stimulus; the model decides what the RAM must do on this edge.
  task automatic step(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic re, input logic [2:0] ra);
    logic [31:0] old_w, new_w;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    if (!rst && init_left == 0) begin
      if (re) begin
        old_w = mdl[ra];
        new_w = old_w;
        if (we && wa == ra)
          for (int i = 0; i < 4; i++) if (be[i]) new_w[8*i +: 8] = wd[8*i +: 8];
        q0.push_back(old_w);
        q1.push_back(new_w);
      end
      if (we)
        for (int i = 0; i < 4; i++) if (be[i]) mdl[wa][8*i +: 8] = wd[8*i +: 8];
    end
    @(posedge clk);
    if (!rst && init_left > 0) init_left--;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 3'd0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    for (int a = 0; a < 8; a++) mdl[a] = '0;
    init_left = 8;
    #1;
    check("rst_valid0", {31'd0, rd_valid0}, 32'd0);
    check("rst_valid1", {31'd0, rd_valid1}, 32'd0);
    check("rst_data0", rd_data0, 32'd0);
    check("rst_data1", rd_data1, 32'd0);
    check("rst_busy0", {31'd0, init_busy0}, 32'd1);
    check("rst_busy1", {31'd0, init_busy1}, 32'd1);
    idle(2);
    rst = 1'b0;
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    logic [31:0] e;
    if (mon_on) begin
      if (rst) begin
        q0.delete(); q1.delete();
        last0 = '0; last1 = '0;
      end
      check("busy0", {31'd0, init_busy0}, {31'd0, (rst || init_left > 0)});
      check("busy1", {31'd0, init_busy1}, {31'd0, (rst || init_left > 0)});
      if (rd_valid0) begin
        if (q0.size() == 0) check("spurious_valid0", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          check("rd0", rd_data0, e);
          last0 = e;
        end
      end else check("hold0", rd_data0, last0);
      if (rd_valid1) begin
        if (q1.size() == 0) check("spurious_valid1", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("rd1", rd_data1, e);
          last1 = e;
        end
      end else check("hold1", rd_data1, last1);
    end
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    for (int a = 0; a < 8; a++) mdl[a] = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    rst = 1'b0;

    // Requests held high during INIT must be ignored.
    for (int k = 0; k < 8; k++)
      step(1'b1, 3'(k), 32'hFFFF_0000 | 32'(k), 4'hF, 1'b1, 3'(k));
    check("busy_after_init", {31'd0, init_busy0}, 32'd0);

    // Array reads back all zero.
    for (int a = 0; a < 8; a++) step(1'b0, 3'd0, 32'd0, 4'd0, 1'b1, 3'(a));
    idle(3);

    // Full write then byte-masked write.
    step(1'b1, 3'd3, 32'hDEAD_BEEF, 4'hF, 1'b0, 3'd0);
    step(1'b0, 3'd0, 32'd0, 4'd0, 1'b1, 3'd3);
    step(1'b1, 3'd3, 32'h1122_3344, 4'b0101, 1'b0, 3'd0);
    step(1'b0, 3'd0, 32'd0, 4'd0, 1'b1, 3'd3);
    idle(3);
    check("be_merge_model", mdl[3], 32'hDE22_BE44);

    // Same-address collision, then follow-up read.
    step(1'b1, 3'd5, 32'hAAAA_AAAA, 4'hF, 1'b0, 3'd0);
    step(1'b1, 3'd5, 32'h5555_5555, 4'hF, 1'b1, 3'd5);
    step(1'b0, 3'd0, 32'd0, 4'd0, 1'b1, 3'd5);
    // Partial-enable collision.
    step(1'b1, 3'd5, 32'h1234_5678, 4'b1001, 1'b1, 3'd5);
    idle(3);

    // Fill, burst read, reset mid-burst.
    for (int a = 0; a < 8; a++) step(1'b1, 3'(a), $urandom | 32'h1, 4'hF, 1'b0, 3'd0);
    for (int a = 0; a < 4; a++) step(1'b0, 3'd0, 32'd0, 4'd0, 1'b1, 3'(a));
    do_reset();
    idle(8);
    for (int a = 0; a < 8; a++) step(1'b0, 3'd0, 32'd0, 4'd0, 1'b1, 3'(a));
    idle(3);

    // Random traffic with one more reset part way through.
    for (int k = 0; k < 400; k++) begin
      if (k == 200) begin
        do_reset();
      end
      step(($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), $urandom,
           4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)));
    end
    idle(4);

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
